// File: rtl/trinity_parent_selector.sv
// Tournament parent selector: population store, LFSR-driven two-tournament draw, valid/ready pair output.
// Optional macro ELITE_TRACK_EN adds all-time-best tracking outputs (elite_*).
module trinity_parent_selector #(
  parameter int          POP_SIZE  = 16,
  parameter int          IDX_W     = 4,
  parameter int          TOUR_K    = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [63:0]      wr_weights,
  input  logic [31:0]      wr_fitness,
  input  logic             clear,
  input  logic             sel_start,
  output logic             sel_busy,
  output logic             parent_valid,
  input  logic             parent_ready,
  output logic [63:0]      parent_weights_a,
  output logic [63:0]      parent_weights_b,
  output logic [IDX_W-1:0] parent_idx_a,
  output logic [IDX_W-1:0] parent_idx_b,
  output logic [31:0]      parent_fitness_a,
  output logic [31:0]      parent_fitness_b,
`ifdef ELITE_TRACK_EN
  output logic [63:0]      elite_weights,
  output logic [31:0]      elite_fitness,
  output logic [IDX_W-1:0] elite_idx,
  output logic             elite_valid,
`endif
  output logic [IDX_W:0]   valid_count
);

  localparam int CNT_W = (TOUR_K > 1) ? $clog2(TOUR_K) : 1;

  typedef enum logic [1:0] {IDLE, TOUR_A, TOUR_B, DONE} state_t;

  logic [63:0] weights_mem [POP_SIZE];
  logic [31:0] fitness_mem [POP_SIZE];

  state_t              state_q, state_d;
  logic [POP_SIZE-1:0] valid_q, valid_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    tally_q, tally_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [31:0]         best_fit_q, best_fit_d;
  logic [63:0]         best_w_q, best_w_d;
  logic                busy_q, busy_d;
  logic                pvalid_q, pvalid_d;
  logic [IDX_W-1:0]    idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [31:0]         fit_a_q, fit_a_d, fit_b_q, fit_b_d;
  logic [63:0]         w_a_q, w_a_d, w_b_q, w_b_d;

  logic [IDX_W-1:0] cand_idx;
  logic             cand_valid, cand_take, cand_last;
  logic [31:0]      cand_fit;
  logic [63:0]      cand_w;
  logic [IDX_W-1:0] win_idx;
  logic [31:0]      win_fit;
  logic [63:0]      win_w;

  // Candidate comes from this cycle's LFSR value; ties keep the earlier best.
  assign cand_idx   = lfsr_q[IDX_W-1:0];
  assign cand_valid = valid_q[cand_idx];
  assign cand_fit   = fitness_mem[cand_idx];
  assign cand_w     = weights_mem[cand_idx];
  assign cand_take  = cand_valid && ((tally_q == '0) || (cand_fit > best_fit_q));
  assign cand_last  = cand_valid && (tally_q == CNT_W'(TOUR_K - 1));
  assign win_idx    = cand_take ? cand_idx : best_idx_q;
  assign win_fit    = cand_take ? cand_fit : best_fit_q;
  assign win_w      = cand_take ? cand_w   : best_w_q;

  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      weights_mem[wr_idx] <= wr_weights;
      fitness_mem[wr_idx] <= wr_fitness;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    count_d    = count_q;
    tally_d    = tally_q;
    best_idx_d = best_idx_q;
    best_fit_d = best_fit_q;
    best_w_d   = best_w_q;
    busy_d     = busy_q;
    pvalid_d   = pvalid_q;
    idx_a_d    = idx_a_q;
    idx_b_d    = idx_b_q;
    fit_a_d    = fit_a_q;
    fit_b_d    = fit_b_q;
    w_a_d      = w_a_q;
    w_b_d      = w_b_q;
    lfsr_d     = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

    if (clear) begin
      valid_d = '0;
      count_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      if (!valid_q[wr_idx]) count_d = count_q + 1'b1;
    end

    if (clear) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      pvalid_d = 1'b0;
      tally_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_start && (count_q != '0)) begin
            state_d = TOUR_A;
            busy_d  = 1'b1;
            tally_d = '0;
          end
        end
        TOUR_A, TOUR_B: begin
          if (cand_valid) begin
            best_idx_d = win_idx;
            best_fit_d = win_fit;
            best_w_d   = win_w;
            if (cand_last) begin
              tally_d = '0;
              if (state_q == TOUR_A) begin
                idx_a_d = win_idx;
                fit_a_d = win_fit;
                w_a_d   = win_w;
                state_d = TOUR_B;
              end else begin
                idx_b_d = win_idx;
                fit_b_d = win_fit;
                w_b_d   = win_w;
                state_d = DONE;
              end
            end else begin
              tally_d = tally_q + 1'b1;
            end
          end
        end
        DONE: begin
          // First DONE cycle presents the pair; it then holds until accepted.
          if (!pvalid_q) begin
            pvalid_d = 1'b1;
          end else if (parent_ready) begin
            pvalid_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      count_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      tally_q    <= '0;
      best_idx_q <= '0;
      best_fit_q <= '0;
      best_w_q   <= '0;
      busy_q     <= 1'b0;
      pvalid_q   <= 1'b0;
      idx_a_q    <= '0;
      idx_b_q    <= '0;
      fit_a_q    <= '0;
      fit_b_q    <= '0;
      w_a_q      <= '0;
      w_b_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      lfsr_q     <= lfsr_d;
      tally_q    <= tally_d;
      best_idx_q <= best_idx_d;
      best_fit_q <= best_fit_d;
      best_w_q   <= best_w_d;
      busy_q     <= busy_d;
      pvalid_q   <= pvalid_d;
      idx_a_q    <= idx_a_d;
      idx_b_q    <= idx_b_d;
      fit_a_q    <= fit_a_d;
      fit_b_q    <= fit_b_d;
      w_a_q      <= w_a_d;
      w_b_q      <= w_b_d;
    end
  end

  assign sel_busy         = busy_q;
  assign parent_valid     = pvalid_q;
  assign parent_idx_a     = idx_a_q;
  assign parent_idx_b     = idx_b_q;
  assign parent_fitness_a = fit_a_q;
  assign parent_fitness_b = fit_b_q;
  assign parent_weights_a = w_a_q;
  assign parent_weights_b = w_b_q;
  assign valid_count      = count_q;

`ifdef ELITE_TRACK_EN
  logic [63:0]      elite_w_q, elite_w_d;
  logic [31:0]      elite_fit_q, elite_fit_d;
  logic [IDX_W-1:0] elite_idx_q, elite_idx_d;
  logic             elite_valid_q, elite_valid_d;

  // Best write ever seen; overwriting that slot lower never demotes it.
  always_comb begin
    elite_w_d     = elite_w_q;
    elite_fit_d   = elite_fit_q;
    elite_idx_d   = elite_idx_q;
    elite_valid_d = elite_valid_q;
    if (clear) begin
      elite_w_d     = '0;
      elite_fit_d   = '0;
      elite_idx_d   = '0;
      elite_valid_d = 1'b0;
    end else if (wr_en && (!elite_valid_q || (wr_fitness > elite_fit_q))) begin
      elite_w_d     = wr_weights;
      elite_fit_d   = wr_fitness;
      elite_idx_d   = wr_idx;
      elite_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elite_w_q     <= '0;
      elite_fit_q   <= '0;
      elite_idx_q   <= '0;
      elite_valid_q <= 1'b0;
    end else begin
      elite_w_q     <= elite_w_d;
      elite_fit_q   <= elite_fit_d;
      elite_idx_q   <= elite_idx_d;
      elite_valid_q <= elite_valid_d;
    end
  end

  assign elite_weights = elite_w_q;
  assign elite_fitness = elite_fit_q;
  assign elite_idx     = elite_idx_q;
  assign elite_valid   = elite_valid_q;
`endif

endmodule

// File: tb/tb_trinity_parent_selector.sv
// Scoreboard bench for trinity_parent_selector: directed selections checked against an LFSR tournament model.
module tb_trinity_parent_selector;

  localparam int POP = 16;
  localparam int IW  = 4;
  localparam int K   = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [63:0]   wr_weights = '0;
  logic [31:0]   wr_fitness = '0;
  logic          clear = 1'b0;
  logic          sel_start = 1'b0;
  logic          parent_ready = 1'b0;
  logic          sel_busy, parent_valid;
  logic [63:0]   parent_weights_a, parent_weights_b;
  logic [IW-1:0] parent_idx_a, parent_idx_b;
  logic [31:0]   parent_fitness_a, parent_fitness_b;
  logic [IW:0]   valid_count;
`ifdef ELITE_TRACK_EN
  logic [63:0]   elite_weights;
  logic [31:0]   elite_fitness;
  logic [IW-1:0] elite_idx;
  logic          elite_valid;
`endif

  trinity_parent_selector #(.POP_SIZE(POP), .IDX_W(IW), .TOUR_K(K), .LFSR_SEED(32'hACE1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_weights(wr_weights), .wr_fitness(wr_fitness), .clear(clear),
    .sel_start(sel_start), .sel_busy(sel_busy), .parent_valid(parent_valid),
    .parent_ready(parent_ready), .parent_weights_a(parent_weights_a),
    .parent_weights_b(parent_weights_b), .parent_idx_a(parent_idx_a),
    .parent_idx_b(parent_idx_b), .parent_fitness_a(parent_fitness_a),
    .parent_fitness_b(parent_fitness_b),
`ifdef ELITE_TRACK_EN
    .elite_weights(elite_weights), .elite_fitness(elite_fitness),
    .elite_idx(elite_idx), .elite_valid(elite_valid),
`endif
    .valid_count(valid_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] ia, ib;
    logic [31:0]   fa, fb;
    logic [63:0]   wa, wb;
    int            rise;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_exp;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] m_lfsr;
  logic [63:0] m_w [POP];
  logic [31:0] m_f [POP];
  logic        m_v [POP];
  logic        pv_prev = 1'b0;

  function automatic logic [31:0] lfsrNext(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) m_lfsr <= 32'hACE1;
    else          m_lfsr <= lfsrNext(m_lfsr);

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mkGenome(input int i);
    logic [63:0] g;
    g = 64'h5555_5555_5555_5555;
    for (int b = 0; b < 4; b++) begin
      g[2*b +: 2]    = i[b] ? 2'b10 : 2'b00;
      g[40+2*b +: 2] = i[b] ? 2'b00 : 2'b10;
    end
    return g;
  endfunction

  // Reference tournament: one draw per cycle starting from the LFSR value after acceptance.
  function automatic exp_t runModel(input logic [31:0] seed, input int accept);
    exp_t          e;
    logic [31:0]   s;
    int            draws, n;
    logic [IW-1:0] bi, c;
    logic [31:0]   bf;
    s = seed;
    draws = 0;
    for (int t = 0; t < 2; t++) begin
      n = 0; bi = '0; bf = '0;
      while (n < K && draws < 4096) begin
        c = s[IW-1:0];
        draws++;
        if (m_v[c]) begin
          if (n == 0 || m_f[c] > bf) begin bi = c; bf = m_f[c]; end
          n++;
        end
        s = lfsrNext(s);
      end
      if (t == 0) begin e.ia = bi; e.fa = bf; e.wa = m_w[bi]; end
      else        begin e.ib = bi; e.fb = bf; e.wb = m_w[bi]; end
    end
    e.rise = accept + draws + 1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every new parent pair must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (parent_valid === 1'b1 && pv_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_valid: got parent_valid 1 at cycle %0d, expected no pair", cyc);
      end else begin
        e = sb_q.pop_front();
        checkOutput("idx_a", parent_idx_a, e.ia);
        checkOutput("idx_b", parent_idx_b, e.ib);
        checkOutput("fit_a", parent_fitness_a, e.fa);
        checkOutput("fit_b", parent_fitness_b, e.fb);
        checkOutput("weights_a", parent_weights_a, e.wa);
        checkOutput("weights_b", parent_weights_b, e.wb);
        checkOutput("rise_cycle", cyc, e.rise);
      end
    end
    pv_prev = parent_valid;
  end

  task automatic writeSlot(input int idx, input logic [31:0] f);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_weights = mkGenome(idx); wr_fitness = f;
    @(negedge clk);
    wr_en = 1'b0;
    m_w[idx] = mkGenome(idx); m_f[idx] = f; m_v[idx] = 1'b1;
  endtask

  task automatic clearPulse();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    for (int i = 0; i < POP; i++) m_v[i] = 1'b0;
  endtask

  task automatic applyStimulus(input bit expect_accept);
    @(negedge clk); sel_start = 1'b1;
    @(posedge clk); #1; sel_start = 1'b0;
    if (expect_accept) begin
      last_exp = runModel(m_lfsr, cyc);
      sb_q.push_back(last_exp);
    end
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (parent_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checkOutput("valid_timeout", parent_valid, 1);
  endtask

  task automatic takePair();
    @(negedge clk); parent_ready = 1'b1;
    @(posedge clk); #1; parent_ready = 1'b0;
    checkOutput("valid_drop", parent_valid, 0);
    checkOutput("busy_drop", sel_busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t tmp;
    for (int i = 0; i < POP; i++) begin m_v[i] = 1'b0; m_f[i] = '0; m_w[i] = '0; end

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", sel_busy, 0);
    checkOutput("rst_valid", parent_valid, 0);
    checkOutput("rst_count", valid_count, 0);
    checkOutput("rst_idx_a", parent_idx_a, 0);
    checkOutput("rst_weights_b", parent_weights_b, 0);
`ifdef ELITE_TRACK_EN
    checkOutput("rst_elite_valid", elite_valid, 0);
`endif
    reset_n = 1'b1;

    // Empty population: start must be ignored.
    applyStimulus(0);
    repeat (2) @(negedge clk);
    checkOutput("empty_start_busy", sel_busy, 0);

    // Single valid slot wins both tournaments.
    writeSlot(5, 7);
    checkOutput("count_one", valid_count, 1);
    applyStimulus(1);
    waitValid();
    checkOutput("single_idx_a", parent_idx_a, 5);
    checkOutput("single_idx_b", parent_idx_b, 5);
    checkOutput("single_fit_a", parent_fitness_a, 7);
    checkOutput("single_fit_b", parent_fitness_b, 7);
    checkOutput("single_w_a", parent_weights_a, mkGenome(5));
    takePair();

    // Full population, fitness = index*100.
    for (int i = 0; i < POP; i++) writeSlot(i, 32'(i * 100));
    checkOutput("count_full", valid_count, 16);
    applyStimulus(1);
    checkOutput("full_latency_exp", last_exp.rise - cyc, 2 * K + 1);
    waitValid();
    takePair();

    // Hold in DONE with ready low; a start during DONE is ignored.
    applyStimulus(1);
    waitValid();
    for (int j = 0; j < 10; j++) begin
      sel_start = (j == 3);
      @(negedge clk);
      checkOutput("hold_valid", parent_valid, 1);
      checkOutput("hold_idx_a", parent_idx_a, last_exp.ia);
      checkOutput("hold_fit_b", parent_fitness_b, last_exp.fb);
    end
    sel_start = 1'b0;
    takePair();
    applyStimulus(1);
    checkOutput("restart_busy", sel_busy, 1);
    waitValid();
    takePair();

    // Tie: slots 2 and 9 at 500, everything else 0.
    clearPulse();
    for (int i = 0; i < POP; i++) writeSlot(i, (i == 2 || i == 9) ? 32'd500 : 32'd0);
    applyStimulus(1);
    waitValid();
    takePair();

    // Clear during TOUR_A aborts the selection and empties the population.
    applyStimulus(0);
    clearPulse();
    checkOutput("clr_busy", sel_busy, 0);
    checkOutput("clr_valid", parent_valid, 0);
    checkOutput("clr_count", valid_count, 0);
    applyStimulus(0);
    repeat (3) @(negedge clk);
    checkOutput("clr_start_ignored", sel_busy, 0);
`ifdef ELITE_TRACK_EN
    checkOutput("clr_elite_valid", elite_valid, 0);
    writeSlot(1, 300);
    writeSlot(1, 200);
    checkOutput("elite_fit", elite_fitness, 300);
    checkOutput("elite_idx", elite_idx, 1);
    checkOutput("elite_valid", elite_valid, 1);
`endif

    // Async reset in the middle of TOUR_B.
    for (int i = 0; i < POP; i++) writeSlot(i, 32'(i * 100 + 1));
    applyStimulus(0);
    tmp = runModel(m_lfsr, cyc);
    repeat (K + 2) @(negedge clk);
    checkOutput("midb_busy", sel_busy, 1);
    checkOutput("midb_idx_a", parent_idx_a, tmp.ia);
    #2; reset_n = 1'b0; #1;
    checkOutput("arst_busy", sel_busy, 0);
    checkOutput("arst_valid", parent_valid, 0);
    checkOutput("arst_idx_a", parent_idx_a, 0);
    checkOutput("arst_fit_a", parent_fitness_a, 0);
    checkOutput("arst_w_a", parent_weights_a, 0);
    checkOutput("arst_count", valid_count, 0);
    for (int i = 0; i < POP; i++) m_v[i] = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    // Post-reset selection confirms the LFSR restarted from its seed.
    for (int i = 0; i < POP; i++) writeSlot(i, 32'(i * 100 + 1));
    applyStimulus(1);
    waitValid();
    takePair();

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trinity_parent_selector.md
Name: trinity_parent_selector

Overview:
Tournament-selection stage directly upstream of trinity_evolution_engine.
- Holds a population of 64-bit balanced-ternary genomes (32 trits, {-1,0,+1} -> {00,01,10}), each with a 32-bit fitness score written back from fitness_evaluator.
- On request, draws two tournaments with an internal LFSR and presents the winners as parent_weights_a / parent_weights_b, using a valid/ready handshake.

Parameters:
POP_SIZE, 16, number of population slots; must be a power of two, 2..256.
IDX_W, 4, index width = log2(POP_SIZE).
TOUR_K, 4, candidates drawn per tournament; range 1..16.
LFSR_SEED, 32'hACE1, LFSR value after reset; must be nonzero.

Ports:
clk  in  1  system clock, all state on rising edge.
reset_n  in  1  asynchronous active-low reset.
wr_en  in  1  write one population slot this cycle.
wr_idx  in  IDX_W  slot written.
wr_weights  in  64  genome written.
wr_fitness  in  32  fitness score written.
clear  in  1  invalidate all slots (synchronous).
sel_start  in  1  request one parent pair.
sel_busy  out  1  selection in progress (TOUR_A/TOUR_B/DONE).
parent_valid  out  1  parent pair available.
parent_ready  in  1  consumer accepts pair.
parent_weights_a  out  64  winner of tournament A.
parent_weights_b  out  64  winner of tournament B.
parent_idx_a  out  IDX_W  slot of winner A.
parent_idx_b  out  IDX_W  slot of winner B.
parent_fitness_a  out  32  fitness of winner A.
parent_fitness_b  out  32  fitness of winner B.
valid_count  out  IDX_W+1  number of valid slots.

Behaviour:
- Reset (reset_n low, asynchronous): all slot valid bits 0, valid_count 0, state IDLE, sel_busy 0, parent_valid 0, all parent_* outputs 0, lfsr = LFSR_SEED. Slot weight/fitness storage is not reset.
- LFSR: 32-bit, shift left, feedback bit = lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0], advances every cycle out of reset. Candidate index = lfsr[IDX_W-1:0] of the current cycle.
- Writes: a write updates the slot and sets its valid bit at the clock edge. valid_count increments only when writing a previously invalid slot.
- clear: zeroes all valid bits and valid_count. clear wins over a same-cycle wr_en. An in-flight selection aborts to IDLE with parent_valid 0.
- FSM states: IDLE, TOUR_A, TOUR_B, DONE.
- IDLE: if sel_start and valid_count != 0, go to TOUR_A and set sel_busy. If valid_count == 0, sel_start is ignored.
- TOUR_A / TOUR_B: one candidate per cycle, read from storage as registered at that edge.
  - An invalid candidate is ignored and does not count toward TOUR_K.
  - The first valid candidate seeds best.
  - Each later candidate replaces best only if its fitness is strictly greater (unsigned); ties keep the earlier candidate.
  - After TOUR_K valid candidates, latch best into the _a outputs (TOUR_A) or _b outputs (TOUR_B), then advance.
  - A and B may be the same slot.
- Latency: with all slots valid, parent_valid rises exactly 2*TOUR_K+1 cycles after the sel_start acceptance edge.
- DONE: parent_valid is held high and outputs are stable until parent_ready. On the handshake edge, parent_valid and sel_busy go 0 and the FSM returns to IDLE; a new start is accepted from the next cycle. sel_start while busy is ignored.
- A write to a slot during a tournament is visible to candidates drawn after that edge. Latched parent outputs are not retroactively changed.
- wr_idx is always in range (power-of-two POP_SIZE), so there is no wrap handling.

Optional Feature:
ELITE_TRACK_EN:
- Defined: adds outputs elite_weights[63:0], elite_fitness[31:0], elite_idx[IDX_W-1:0], elite_valid.
  - Tracks the all-time best write since the last reset/clear; it replaces on strictly greater fitness, or on the first write after clear.
  - Updated the cycle after the write.
  - Not lowered if that slot is later overwritten with lower fitness.
  - Reset/clear: all elite outputs 0.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset with reset_n low mid-TOUR_B -> outputs 0 immediately (before the next clk edge), state IDLE, valid_count 0, lfsr 32'hACE1 after release.
- Write 16 slots, fitness = index*100, TOUR_K=16, sel_start -> parent_valid at +33 cycles; each winner is the highest-fitness slot among its 16 draws, matching a reference model of the LFSR sequence.
- Only slot 5 valid (fitness 7), sel_start -> parent_idx_a = parent_idx_b = 5, fitness 7/7, weights equal to the slot 5 contents.
- Slots 2 and 9 both fitness 500, all others 0, TOUR_K=4 -> tie resolved to whichever was drawn first, per the model.
- parent_ready held low 10 cycles in DONE -> outputs stable, sel_start ignored; ready pulse -> valid drops next edge, new start accepted the following cycle.
- clear asserted during TOUR_A -> IDLE, valid_count 0; subsequent sel_start ignored. With ELITE_TRACK_EN: elite_valid 0 after clear; writes of 300 then 200 -> elite_fitness 300.
